// File: rtl/mp_add_seq.sv
// mp_add_seq: byte-serial multi-precision add/sub sequencer for cla_8; define MPADD_OVF_EN to add out_ovf
module mp_add_seq #(
  parameter int NBYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [8*NBYTES-1:0]   in_a,
  input  logic [8*NBYTES-1:0]   in_b,
  input  logic                  in_cin,
  input  logic                  in_sub,
  output logic [7:0]            add_a,
  output logic [7:0]            add_b,
  output logic                  add_cin,
  input  logic [7:0]            add_s,
  input  logic                  add_cout,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [8*NBYTES-1:0]   out_sum,
`ifdef MPADD_OVF_EN
  output logic                  out_ovf,
`endif
  output logic                  out_cout
);
  localparam int W = 8*NBYTES;
  localparam int CW = $clog2(NBYTES) + 1;
  localparam logic [CW-1:0] LAST = CW'(NBYTES - 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t r_state, w_next;
  logic [W-1:0] r_a, r_b, r_acc, w_sum;
  logic [CW-1:0] r_cnt;
  logic r_carry, w_last, w_run;
  if (NBYTES == 1) begin : g_one
    assign w_sum = add_s;
  end else begin : g_multi
    assign w_sum = {add_s, r_acc[W-1:8]};
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else r_state <= w_next;
  end
  always_comb begin
    w_run = r_state == RUN;
    w_last = w_run && r_cnt == LAST;
    in_ready = r_state == IDLE;
    out_valid = r_state == DONE;
    add_a = w_run ? r_a[7:0] : 8'd0;
    add_b = w_run ? r_b[7:0] : 8'd0;
    add_cin = w_run ? r_carry : 1'b0;
    w_next = r_state == IDLE ? (in_valid ? RUN : IDLE) :
             w_run ? (w_last ? DONE : RUN) :
             r_state == DONE ? (out_ready ? IDLE : DONE) : IDLE;
  end
  // The top byte is on the adder bus during the last RUN cycle, so sign bits come straight from it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a <= '0;
      r_b <= '0;
      r_acc <= '0;
      r_cnt <= '0;
      r_carry <= 1'b0;
      out_sum <= '0;
      out_cout <= 1'b0;
`ifdef MPADD_OVF_EN
      out_ovf <= 1'b0;
`endif
    end else if (in_ready && in_valid) begin
      r_a <= in_a;
      r_b <= in_sub ? ~in_b : in_b;
      r_carry <= in_sub | in_cin;
      r_cnt <= '0;
    end else if (w_run) begin
      r_acc <= w_sum;
      r_carry <= add_cout;
      r_a <= r_a >> 8;
      r_b <= r_b >> 8;
      r_cnt <= r_cnt + CW'(1);
      if (w_last) begin
        out_sum <= w_sum;
        out_cout <= add_cout;
`ifdef MPADD_OVF_EN
        out_ovf <= (add_a[7] == add_b[7]) && (add_s[7] != add_a[7]);
`endif
      end
    end
  end
endmodule

// File: tb/tb_mp_add_seq.sv
// tb_mp_add_seq: directed checks of mp_add_seq (NBYTES=4) driving a behavioural 8-bit adder
module tb_mp_add_seq;
  logic clk = 1'b0, rst = 1'b1;
  logic in_valid = 1'b0, in_cin = 1'b0, in_sub = 1'b0, out_ready = 1'b0;
  logic in_ready, add_cin, add_cout, out_valid, out_cout;
  logic [31:0] in_a = '0, in_b = '0, out_sum;
  logic [7:0] add_a, add_b, add_s;
`ifdef MPADD_OVF_EN
  logic out_ovf;
`endif
  int n_chk = 0, n_err = 0;
  always #5 clk = ~clk;
  assign {add_cout, add_s} = {1'b0, add_a} + {1'b0, add_b} + {8'd0, add_cin};
  mp_add_seq #(.NBYTES(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_sub(in_sub),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin), .add_s(add_s), .add_cout(add_cout),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
`ifdef MPADD_OVF_EN
    .out_ovf(out_ovf),
`endif
    .out_cout(out_cout)
  );
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic start(input logic [31:0] a, input logic [31:0] b, input logic cin, input logic sub);
    check("in_ready_before", in_ready, 1);
    in_a = a; in_b = b; in_cin = cin; in_sub = sub; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; in_a = '1; in_b = '1; in_cin = 1'b0; in_sub = 1'b0;
  endtask
  task automatic wait_done(input string tag, input logic [31:0] s, input logic c, input logic ovf);
    int n;
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_lat"}, n, 4);
    check({tag, "_sum"}, out_sum, s);
    check({tag, "_cout"}, out_cout, c);
`ifdef MPADD_OVF_EN
    check({tag, "_ovf"}, out_ovf, ovf);
`else
    if (ovf === 1'bx) check({tag, "_ovf"}, 0, 1);
`endif
  endtask
  task automatic release_out(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_vld_low"}, out_valid, 0);
    check({tag, "_rdy_high"}, in_ready, 1);
  endtask
  task automatic op(input string tag, input logic [31:0] a, input logic [31:0] b, input logic cin,
                    input logic sub, input logic [31:0] s, input logic c, input logic ovf);
    start(a, b, cin, sub);
    wait_done(tag, s, c, ovf);
    release_out(tag);
  endtask
  initial begin
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_sum", out_sum, 0);
    check("rst_out_cout", out_cout, 0);
    check("rst_add", {add_a, add_b, add_cin}, 0);
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;
    op("add_ff_1", 32'h000000FF, 32'h00000001, 1'b0, 1'b0, 32'h00000100, 1'b0, 1'b0);
    op("add_cin_ripple", 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 32'h00000000, 1'b1, 1'b0);
    op("sub_borrow", 32'h00000005, 32'h00000007, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0);
    op("sub_noborrow", 32'h12345678, 32'h02345678, 1'b1, 1'b1, 32'h10000000, 1'b1, 1'b0);
    start(32'hA5A5A5A5, 32'h5A5A5A5A, 1'b1, 1'b0);
    wait_done("bp", 32'h00000000, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_a = 32'h11111111; in_b = 32'h22222222;
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("bp_valid", out_valid, 1);
      check("bp_sum", out_sum, 32'h00000000);
      check("bp_cout", out_cout, 1);
      check("bp_in_ready", in_ready, 0);
    end
    release_out("bp");
    start(32'h11223344, 32'h01010101, 1'b0, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("mid_add_a", add_a, 8'h22);
    rst = 1'b1;
    #1;
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_out_sum", out_sum, 0);
    check("mid_rst_out_cout", out_cout, 0);
    check("mid_rst_add", {add_a, add_b, add_cin}, 0);
    @(posedge clk); #1 rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check("post_rst_no_valid", out_valid, 0);
    end
    op("after_rst", 32'h00000010, 32'h00000020, 1'b0, 1'b0, 32'h00000030, 1'b0, 1'b0);
    op("ovf_add", 32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1);
    op("ovf_sub", 32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1);
    op("no_ovf", 32'h00000001, 32'h00000001, 1'b0, 1'b0, 32'h00000002, 1'b0, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/mp_add_seq.md
Name: mp_add_seq

Overview:
- Multi-precision add/subtract sequencer that sits directly upstream of the team's 8-bit carry-lookahead adder (cla_8).
- Accepts NBYTES-wide operands over a valid/ready handshake and feeds the adder one byte pair per cycle, LSB first.
- Chains the carry through a register between bytes and captures each 8-bit sum byte.
- Presents the full-width result downstream over valid/ready.

Parameters:
- NBYTES, 4, operand width in bytes (legal 1..16); data width W = 8*NBYTES.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous and active-high; clears all state.
- in_valid  input  1  operand request valid.
- in_ready  output  1  block can accept a request; high only in IDLE.
- in_a  input  W  operand A.
- in_b  input  W  operand B.
- in_cin  input  1  carry-in for add; ignored for subtract.
- in_sub  input  1  0 = A+B+cin, 1 = A-B (two's complement).
- add_a  output  8  byte of A to cla_8 .a.
- add_b  output  8  byte of effective B to cla_8 .b.
- add_cin  output  1  chained carry to cla_8 .cin.
- add_s  input  8  cla_8 .s, combinational return.
- add_cout  input  1  cla_8 .cout, combinational return.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- out_sum  output  W  result.
- out_cout  output  1  final carry-out (for subtract, 1 = no borrow).

Behaviour:
Reset:
- State = IDLE.
- in_ready = 1, out_valid = 0, out_sum = 0, out_cout = 0.
- add_a, add_b and add_cin = 0.
- Byte counter = 0, carry register = 0.

FSM states: IDLE, RUN, DONE.

IDLE:
- in_ready = 1.
- On in_valid & in_ready:
  - Latch in_a into the A shift register.
  - Latch (in_sub ? ~in_b : in_b) into the B shift register.
  - Carry register <= (in_sub ? 1 : in_cin).
  - Counter <= 0. Go to RUN.
- Adder drive outputs are held at 0.

RUN:
- in_ready = 0.
- Each cycle, combinationally drive:
  - add_a = A_sh[7:0]
  - add_b = B_sh[7:0]
  - add_cin = carry register
- On the clock edge:
  - Sum byte [counter] <= add_s.
  - Carry register <= add_cout.
  - Shift A_sh and B_sh right by 8.
  - Counter += 1.
- When counter == NBYTES-1 on that edge:
  - Go to DONE.
  - out_cout <= add_cout.
  - out_sum takes the assembled value.
- The adder path is single-cycle combinational, so there are no waits.

DONE:
- out_valid = 1.
- out_sum and out_cout are stable and held until out_ready.
- On out_ready: out_valid <= 0, go to IDLE.
- in_ready stays 0 in DONE; a new request cannot be accepted in the same cycle as the output handshake.

Timing:
- Latency: out_valid rises NBYTES cycles after the accepting edge.
- Minimum request-to-request interval is NBYTES+2 cycles.

Boundary conditions:
- NBYTES = 1: exactly one RUN cycle.
- Counter width is clog2(NBYTES)+1 bits; the counter never wraps within an operation.
- out_sum keeps its last value in IDLE. It is only updated at the final RUN edge and is never partially visible while out_valid = 1.
- Reset mid-RUN or mid-DONE: the operation is aborted with no output produced, and all outputs go to reset values immediately (async).
- in_valid is ignored outside IDLE. Operands may change freely after acceptance.

Optional Feature:
- Macro: MPADD_OVF_EN.
- Defined:
  - Adds output port out_ovf (1 bit), the signed overflow of the full-width operation.
  - out_ovf = (A[W-1] == Beff[W-1]) & (S[W-1] != A[W-1]), where Beff is the inverted B for subtract.
  - Registered with out_sum; reset value 0; valid only with out_valid.
- Not defined: the port and its logic are absent; behaviour is otherwise identical.

Test Plan (NBYTES=4, cla_8 instance connected to the adder ports):
1. Add 0x000000FF + 0x00000001, cin=0 -> out_sum=0x00000100, out_cout=0; out_valid asserts exactly 4 cycles after the accept edge.
2. Add 0xFFFFFFFF + 0x00000000, cin=1 -> out_sum=0x00000000, out_cout=1; carry ripples through all 4 bytes.
3. Subtract 0x00000005 - 0x00000007 -> out_sum=0xFFFFFFFE, out_cout=0; subtract 0x12345678 - 0x02345678 -> out_sum=0x10000000, out_cout=1.
4. Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_valid, out_sum and out_cout stable, in_ready=0, in_valid pulses ignored; release -> IDLE next cycle, in_ready=1.
5. Assert rst during the 3rd RUN cycle -> all outputs zero immediately, no out_valid. After release, the request 0x00000010 + 0x00000020 -> 0x00000030.
6. MPADD_OVF_EN defined: add 0x7FFFFFFF + 0x00000001 -> out_sum=0x80000000, out_ovf=1. Subtract 0x80000000 - 0x00000001 -> out_ovf=1. Add 0x00000001 + 0x00000001 -> out_ovf=0.
